// File: rtl/opcode_pkg.sv
// Shared opcode encoding, sequencer FSM states and command payload
// for the opcode processor command path.
package opcode_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CMD_W  = OP_W + DATA_W;

  typedef enum logic [3:0] {
    OPC_PASS  = 4'h0,
    OPC_LOAD  = 4'h1,
    OPC_STORE = 4'h2,
    OPC_NOT   = 4'h3,
    OPC_ADD   = 4'h4,
    OPC_SUB   = 4'h5,
    OPC_AND   = 4'h6,
    OPC_OR    = 4'h7,
    OPC_XOR   = 4'h8,
    OPC_ERR   = 4'hF
  } opcode_t;

  // STORE never writes the processor register, so it is safe to drive while idle
  localparam opcode_t OP_IDLE = OPC_STORE;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic produces_result(opcode_t op);
    return op != OPC_LOAD;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             empty_next_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Pointer advance and next-cycle status flags
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d == {~rd_ptr_d[AW], rd_ptr_d[AW-1:0]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata        = mem_q[rd_ptr_q[AW-1:0]];
  assign full         = full_q;
  assign empty        = empty_q;
  assign empty_next_c = empty_d;

endmodule

// File: rtl/opcode_sequencer.sv
// Buffers upstream commands, issues them one per slot to the opcode processor
// and returns each result-producing opcode's result over a valid/ready port.
module opcode_sequencer
  import opcode_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_opcode,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic [OP_W-1:0]     op_opcode,
  output logic [DATA_W-1:0]   op_data,
  input  logic [DATA_W-1:0]   op_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [OP_W-1:0]     rsp_opcode,
  output logic [DATA_W-1:0]   rsp_result,
  output logic                busy
);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_opcode_q, op_opcode_d;
  logic [DATA_W-1:0]   op_data_q, op_data_d;
  logic [OP_W-1:0]     iss_opcode_q, iss_opcode_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [OP_W-1:0]     rsp_opcode_q, rsp_opcode_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                busy_q, busy_d;

  logic                push, pop;
  logic                fifo_full, fifo_empty, fifo_empty_next;
  cmd_t                fifo_wdata, fifo_rdata;

  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign fifo_wdata = '{opcode: cmd_opcode, data: cmd_data};

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .wdata        (fifo_wdata),
    .pop          (pop),
    .rdata        (fifo_rdata),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .empty_next_c (fifo_empty_next)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    op_opcode_d  = OP_W'(OP_IDLE);
    op_data_d    = '0;
    iss_opcode_d = iss_opcode_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_result_d = rsp_result_q;
    pop          = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // Only issue once the response slot is free (or freeing this cycle)
        if (!fifo_empty && (!rsp_valid_q || rsp_ready)) begin
          pop          = 1'b1;
          op_opcode_d  = fifo_rdata.opcode;
          op_data_d    = fifo_rdata.data;
          iss_opcode_d = fifo_rdata.opcode;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = produces_result(opcode_t'(iss_opcode_q)) ? S_CAPTURE : S_IDLE;
      end
      S_CAPTURE: begin
        rsp_result_d = op_result;
        rsp_opcode_d = iss_opcode_q;
        rsp_valid_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = !fifo_empty_next || (state_d != S_IDLE) || rsp_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_opcode_q  <= OP_W'(OP_IDLE);
      op_data_q    <= '0;
      iss_opcode_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_opcode_q <= '0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_opcode_q  <= op_opcode_d;
      op_data_q    <= op_data_d;
      iss_opcode_q <= iss_opcode_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_result_q <= rsp_result_d;
      busy_q       <= busy_d;
    end
  end

  assign op_opcode  = op_opcode_q;
  assign op_data    = op_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_opcode = rsp_opcode_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;

endmodule
